// File: rtl/x_demux_align.sv
// Pair-alignment stage behind the 80-to-40 MHz DDR demux: hunts a SYNC_A/SYNC_B training pair,
// picks straight or crossed slice pairing, verifies lock and counts training misses while locked.
module x_demux_align #(
  parameter int unsigned    WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_A   = 8'hBC,
  parameter logic [WIDTH-1:0] SYNC_B   = 8'h3C,
  parameter int unsigned    LOCK_COUNT = 4,
  parameter int unsigned    ERR_LIMIT  = 3,
  parameter int unsigned    CNT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic [WIDTH-1:0]     din1st,
  input  logic [WIDTH-1:0]     din2nd,
  input  logic                 train,
  input  logic                 resync,
  output logic [WIDTH-1:0]     dout1st,
  output logic [WIDTH-1:0]     dout2nd,
  output logic                 swap,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] ErrLim  = 4'(ERR_LIMIT);

  typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     p1st_q, p2nd_q;
  logic [WIDTH-1:0]     dout1st_q, dout1st_d;
  logic [WIDTH-1:0]     dout2nd_q, dout2nd_d;
  logic                 swap_q, swap_d;
  logic                 locked_q, locked_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic [3:0]           miss_cnt_q, miss_cnt_d;

  logic       m_s, m_x, m_sel;
  logic [3:0] match_inc, miss_inc;

  // Straight pair is the registered slices; crossed pair spans the registered 2nd and live 1st.
  assign m_s       = (p1st_q == SYNC_A) && (p2nd_q == SYNC_B);
  assign m_x       = (p2nd_q == SYNC_A) && (din1st == SYNC_B);
  assign m_sel     = swap_q ? m_x : m_s;
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = StHunt;
    end else if (train) begin
      unique case (state_q)
        StHunt: begin
          if (m_s || m_x) begin
            state_d = (LOCK_COUNT == 1) ? StLocked : StCheck;
          end
        end
        StCheck: begin
          if (!m_sel) begin
            state_d = StHunt;
          end else if (match_inc == LockCnt) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (!m_sel && (miss_inc == ErrLim)) begin
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    swap_d      = swap_q;
    locked_d    = locked_q;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    dout1st_d   = swap_q ? p2nd_q : p1st_q;
    dout2nd_d   = swap_q ? din1st : p2nd_q;

    if (resync) begin
      swap_d      = 1'b0;
      locked_d    = 1'b0;
      err_cnt_d   = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (train) begin
      unique case (state_q)
        StHunt: begin
          // Straight wins when both pairings match (SYNC_A == SYNC_B).
          if (m_s || m_x) begin
            swap_d      = !m_s;
            match_cnt_d = 4'd1;
            if (LOCK_COUNT == 1) begin
              locked_d = 1'b1;
            end
          end
        end
        StCheck: begin
          if (m_sel) begin
            match_cnt_d = match_inc;
            if (match_inc == LockCnt) begin
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          if (m_sel) begin
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_inc;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
            if (miss_inc == ErrLim) begin
              miss_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      p1st_q      <= '0;
      p2nd_q      <= '0;
      dout1st_q   <= '0;
      dout2nd_q   <= '0;
      swap_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      p1st_q      <= din1st;
      p2nd_q      <= din2nd;
      dout1st_q   <= dout1st_d;
      dout2nd_q   <= dout2nd_d;
      swap_q      <= swap_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign dout1st = dout1st_q;
  assign dout2nd = dout2nd_q;
  assign swap    = swap_q;
  assign locked  = locked_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_x_demux_align.sv
// Scoreboard bench for x_demux_align: stimulus queues hand-computed per-edge expectations,
// a monitor compares them one cycle-tagged entry at a time after each rising edge.
module tb_x_demux_align;

  logic       clock = 1'b0;
  logic       aclr;
  logic [7:0] din1st, din2nd;
  logic       train, resync;

  logic [7:0] dout1st_0, dout2nd_0, err_cnt_0;
  logic       swap_0, locked_0;
  logic [7:0] dout1st_1, dout2nd_1;
  logic [1:0] err_cnt_1;
  logic       swap_1, locked_1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tag    = 0;

  typedef struct {
    int         cyc;
    int         tag;
    bit         inst;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       sw;
    logic       lk;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  x_demux_align u_dut (
    .clock  (clock),
    .aclr   (aclr),
    .din1st (din1st),
    .din2nd (din2nd),
    .train  (train),
    .resync (resync),
    .dout1st(dout1st_0),
    .dout2nd(dout2nd_0),
    .swap   (swap_0),
    .locked (locked_0),
    .err_cnt(err_cnt_0)
  );

  x_demux_align #(
    .ERR_LIMIT(15),
    .CNT_WIDTH(2)
  ) u_sat (
    .clock  (clock),
    .aclr   (aclr),
    .din1st (din1st),
    .din2nd (din2nd),
    .train  (train),
    .resync (resync),
    .dout1st(dout1st_1),
    .dout2nd(dout2nd_1),
    .swap   (swap_1),
    .locked (locked_1),
    .err_cnt(err_cnt_1)
  );

  task automatic cmp(input int t, input string what, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL t%0d %s: got %h, expected %h (cycle %0d)", t, what, act, req, cyc);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    if (!e.inst) begin
      cmp(e.tag, "u_dut.dout1st", dout1st_0, e.d1);
      cmp(e.tag, "u_dut.dout2nd", dout2nd_0, e.d2);
      cmp(e.tag, "u_dut.swap", {7'd0, swap_0}, {7'd0, e.sw});
      cmp(e.tag, "u_dut.locked", {7'd0, locked_0}, {7'd0, e.lk});
      cmp(e.tag, "u_dut.err_cnt", err_cnt_0, e.err);
    end else begin
      cmp(e.tag, "u_sat.dout1st", dout1st_1, e.d1);
      cmp(e.tag, "u_sat.dout2nd", dout2nd_1, e.d2);
      cmp(e.tag, "u_sat.swap", {7'd0, swap_1}, {7'd0, e.sw});
      cmp(e.tag, "u_sat.locked", {7'd0, locked_1}, {7'd0, e.lk});
      cmp(e.tag, "u_sat.err_cnt", {6'd0, err_cnt_1}, e.err);
    end
  endtask

  // Monitor: after each rising edge, consume every expectation tagged for this edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL t%0d stale_entry: got cycle %0d, expected cycle %0d", e.tag, cyc, e.cyc);
      end else begin
        cmp_all(e);
      end
    end
  end

  task automatic st(input logic [7:0] d1, input logic [7:0] d2, input logic tr, input logic rs);
    @(negedge clock);
    din1st = d1;
    din2nd = d2;
    train  = tr;
    resync = rs;
    tag++;
  endtask

  // Expectation for the outputs after the coming rising edge.
  task automatic ex(input bit inst, input logic [7:0] d1, input logic [7:0] d2, input logic sw,
                    input logic lk, input logic [7:0] err);
    exp_t e;
    e.cyc  = cyc + 1;
    e.tag  = tag;
    e.inst = inst;
    e.d1   = d1;
    e.d2   = d2;
    e.sw   = sw;
    e.lk   = lk;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic ex_zero_now(input int t);
    exp_t e;
    e = '{cyc: cyc, tag: t, inst: 1'b0, d1: 8'h00, d2: 8'h00, sw: 1'b0, lk: 1'b0, err: 8'h00};
    cmp_all(e);
    e.inst = 1'b1;
    cmp_all(e);
  endtask

  initial begin
    aclr   = 1'b1;
    din1st = 8'h00;
    din2nd = 8'h00;
    train  = 1'b0;
    resync = 1'b0;
    #1;
    ex_zero_now(0);
    repeat (2) @(negedge clock);

    // Straight lock: locked on the 4th evaluated match edge
    st(8'hBC, 8'h3C, 1, 0); aclr = 1'b0; ex(0, 8'h00, 8'h00, 0, 0, 0);
    repeat (3) begin st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 0); end
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 0);

    // Loss of lock after 3 consecutive bad pairs, then relock
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 0);
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h00, 0, 1, 1);
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h00, 0, 1, 2);
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h00, 0, 0, 3);
    repeat (3) begin st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 3); end
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 3);

    // 2 bad then 1 good: stays locked, err_cnt +2
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 3);
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h00, 0, 1, 4);
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h00, 0, 1, 5);
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 5);

    // Resync clears lock and err_cnt
    st(8'hBC, 8'h3C, 1, 1); ex(0, 8'hBC, 8'h3C, 0, 0, 0);

    // Check abort: 2 good, 1 bad, then 4 good to lock
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 0);
    st(8'hBC, 8'h00, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 0);
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h00, 0, 0, 0);
    repeat (3) begin st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 0); end
    st(8'hBC, 8'h3C, 1, 0); ex(0, 8'hBC, 8'h3C, 0, 1, 0);

    // Swapped lock after resync
    st(8'h3C, 8'hBC, 1, 1); ex(0, 8'hBC, 8'h3C, 0, 0, 0);
    st(8'h3C, 8'hBC, 1, 0); ex(0, 8'h3C, 8'hBC, 1, 0, 0);
    st(8'h3C, 8'hBC, 1, 0); ex(0, 8'hBC, 8'h3C, 1, 0, 0);
    st(8'h3C, 8'hBC, 1, 0); ex(0, 8'hBC, 8'h3C, 1, 0, 0);
    st(8'h3C, 8'hBC, 1, 0); ex(0, 8'hBC, 8'h3C, 1, 1, 0);

    // Half-skewed data pairs (11,22),(33,44) with train low
    st(8'h3C, 8'h11, 0, 0); ex(0, 8'hBC, 8'h3C, 1, 1, 0);
    st(8'h22, 8'h33, 0, 0); ex(0, 8'h11, 8'h22, 1, 1, 0);
    st(8'h44, 8'h55, 0, 0); ex(0, 8'h33, 8'h44, 1, 1, 0);

    // Async reset between edges while locked
    @(posedge clock);
    #3;
    aclr = 1'b1;
    #1;
    tag++;
    ex_zero_now(tag);

    // Saturation on the ERR_LIMIT=15 / CNT_WIDTH=2 instance
    st(8'hBC, 8'h3C, 1, 0); aclr = 1'b0; ex(1, 8'h00, 8'h00, 0, 0, 0);
    repeat (3) begin st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 0, 0); end
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 0);
    st(8'hBC, 8'h00, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 0);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h00, 0, 1, 1);
    st(8'hBC, 8'h00, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 1);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h00, 0, 1, 2);
    st(8'hBC, 8'h00, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 2);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h00, 0, 1, 3);
    st(8'hBC, 8'h00, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 3);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h00, 0, 1, 3);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 1, 3);
    st(8'hBC, 8'h3C, 1, 1); ex(1, 8'hBC, 8'h3C, 0, 0, 0); ex(0, 8'hBC, 8'h3C, 0, 0, 0);
    st(8'hBC, 8'h3C, 1, 0); ex(1, 8'hBC, 8'h3C, 0, 0, 0);

    repeat (3) @(posedge clock);
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL t%0d unchecked_entry: got cycle %0d, expected cycle %0d", e.tag, cyc, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/x_demux_align.md
Name: x_demux_align

Overview:
- Downstream stage of the 80 MHz-to-40 MHz DDR demultiplexer.
- Consumes the 1st-in-time and 2nd-in-time 40 MHz slices and recovers correct pair (frame) alignment. A half-period skew on the link swaps the slice order; this block detects that from a training sync pair and corrects it.
- Delivers aligned pairs plus lock status and an error count to the receive logic.

Parameters:
- WIDTH, 8, bits per slice
- SYNC_A, 8'hBC, training word expected in the first slice of a pair (WIDTH bits)
- SYNC_B, 8'h3C, training word expected in the second slice of a pair (WIDTH bits)
- LOCK_COUNT, 4, consecutive matching pairs required to declare lock (1..15)
- ERR_LIMIT, 3, consecutive mismatching training pairs in LOCKED that force re-hunt (1..15)
- CNT_WIDTH, 8, width of the saturating error counter

Ports:
- clock  in  1  40 MHz clock, same DLL-derived clock as the demux
- aclr  in  1  reset: asynchronous, active-high
- din1st  in  WIDTH  first-in-time slice from the demux
- din2nd  in  WIDTH  second-in-time slice from the demux
- train  in  1  high while the far end transmits continuous SYNC_A/SYNC_B pairs
- resync  in  1  synchronous request to drop lock and re-hunt
- dout1st  out  WIDTH  aligned first slice, registered
- dout2nd  out  WIDTH  aligned second slice, registered
- swap  out  1  0 = straight alignment, 1 = swapped alignment
- locked  out  1  alignment verified
- err_cnt  out  CNT_WIDTH  saturating count of training mismatches while locked

Behaviour:
- aclr resets all registers to 0:
  - outputs dout1st, dout2nd, swap, locked, err_cnt
  - internal registers p1st, p2nd, match counter, miss counter
  - state = HUNT
- Pipeline: at every edge, p1st<=din1st and p2nd<=din2nd.
- Candidate pairs, evaluated each clock:
  - straight S = (p1st, p2nd)
  - crossed X = (p2nd, din1st)
- Output: at each edge, (dout1st, dout2nd) <= S when swap=0, X when swap=1.
  - Latency is 2 clocks from din sampling for straight, 1 clock after the later slice for swapped.
  - Outputs update every clock regardless of state or lock.
- Matches:
  - mS = (p1st==SYNC_A && p2nd==SYNC_B)
  - mX = (p2nd==SYNC_A && din1st==SYNC_B)
  - mSel = mS when swap=0, mX when swap=1
- States:
  - HUNT:
    - locked=0; evaluated only when train=1, otherwise hold.
    - mS -> swap<=0, match cnt<=1, go CHECK.
    - else mX -> swap<=1, match cnt<=1, go CHECK.
    - mS && mX (SYNC_A==SYNC_B) -> straight wins.
    - If LOCK_COUNT==1, go directly to LOCKED.
  - CHECK:
    - With train=1: mSel -> cnt+1; on reaching LOCK_COUNT go LOCKED and set locked<=1 on the same edge.
    - With train=1: !mSel -> cnt<=0, go HUNT; swap holds until the next hunt hit.
    - With train=0: hold state and cnt.
  - LOCKED:
    - locked=1; swap frozen.
    - With train=1: mSel -> miss cnt<=0.
    - With train=1: !mSel -> miss cnt+1 and err_cnt+1, saturating at all-ones.
    - miss cnt reaching ERR_LIMIT -> go HUNT, locked<=0 on that edge, miss cnt<=0.
    - With train=0: no checking; data passes through.
- resync=1 (highest priority, synchronous):
  - state<=HUNT; swap, locked, match/miss counters and err_cnt <= 0.
  - dout continues to update using the new swap value.
- err_cnt holds its value across HUNT/CHECK. It clears only on aclr or resync.
- aclr mid-operation: immediate return to reset values. Operation resumes on the first edge after aclr deasserts.
- Counters never wrap: match and miss counters stop at their limits; err_cnt saturates.

Test Plan:
- Straight lock:
  - Stimulus: aclr pulse, then train=1 with din1st=8'hBC, din2nd=8'h3C every clock.
  - Response: locked=1 on the 4th evaluated match edge, swap=0, dout1st=8'hBC, dout2nd=8'h3C.
- Swapped lock:
  - Stimulus: train=1, din1st=8'h3C, din2nd=8'hBC every clock.
  - Response: swap=1, locked=1 after 4 matches, dout1st=8'hBC, dout2nd=8'h3C.
  - Data check: then train=0 and data pairs (11,22),(33,44) sent half-skewed; dout shows 8'h11/8'h22 then 8'h33/8'h44.
- Check abort:
  - Stimulus: 2 good pairs, 1 bad pair (din2nd=8'h00), then good pairs.
  - Response: locked stays 0 through the bad pair; re-hunt; lock after 4 further good pairs.
- Loss of lock:
  - Stimulus: locked, train=1, 3 consecutive bad pairs.
  - Response: err_cnt=3, locked=0 on the 3rd bad edge, state returns to HUNT.
  - Variant: 2 bad pairs then 1 good pair -> locked stays 1, err_cnt=2.
- Saturation and resync:
  - Stimulus: with ERR_LIMIT=15 and CNT_WIDTH=2, apply repeated bad/good alternation.
  - Response: err_cnt sticks at 3; resync pulse -> err_cnt=0, locked=0, swap=0 next edge.
- Async reset:
  - Stimulus: assert aclr mid-LOCKED between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
